// File: rtl/softmax_seq.sv
// softmax_seq
// Vector sequencer for the softmax streaming unit. The host loads N logits
// into a local buffer and pulses start_i. The block then runs one vector:
//   1. It resets the softmax unit for two cycles while enabling it.
//   2. It streams the N logits, one per cycle.
//   3. It captures the first N results into a result buffer.
// The host reads the result buffer combinationally through rd_addr_i/rd_data_o.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   wr_en_i/addr/data    host write port into the logit buffer (IDLE only)
//   start_i              begin one vector run (ignored while busy)
//   busy_o, done_o       run in progress / one-cycle end-of-run pulse
//   timeout_err_o        sticky: last run aborted waiting for results
//   sum_err_o            sticky: captured probabilities do not sum to 2^OUT_BITS
//   rd_addr_i, rd_data_o combinational result buffer read
//   sm_*                 control and data stream to/from the softmax unit
//
// Optional feature: define SOFTMAX_SEQ_SUM_CHECK_EN to accumulate captured
// results and flag a run whose sum is more than N away from 2^OUT_BITS.
// Without it, sum_err_o is constant 0.

module softmax_seq #(
  parameter int DW       = 32,
  parameter int N        = 32,
  parameter int OUT_BITS = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [$clog2(N)-1:0] wr_addr_i,
  input  logic [DW-1:0]        wr_data_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_err_o,
  output logic                 sum_err_o,
  input  logic [$clog2(N)-1:0] rd_addr_i,
  output logic [DW-1:0]        rd_data_o,
  output logic                 sm_rst_o,
  output logic                 sm_enable_o,
  output logic                 sm_in_valid_o,
  output logic [DW-1:0]        sm_x_o,
  input  logic                 sm_out_valid_i,
  input  logic [DW-1:0]        sm_y_i
);

  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, CLEAR, SEND, WAIT, DONE} state_e;

  state_e        state_q;
  logic [DW-1:0] logitBuf [N];
  logic [DW-1:0] resBuf [N];
  logic [CW-1:0] sendIdx_q;
  logic [CW-1:0] rcvIdx_q;
  logic [CW-1:0] rcvIdx_d;
  logic [TW-1:0] idleCnt_q;
  logic [TW-1:0] idleCnt_d;
  logic          clearCnt_q;
  logic          busy_q;
  logic          done_q;
  logic          timeoutErr_q;
  logic          smRst_q;
  logic          smEnable_q;
  logic          smInValid_q;
  logic [DW-1:0] smX_q;
  logic          capture;

  // A result is captured whenever the unit presents one while we are streaming
  // or waiting, until N samples are held; anything beyond that is dropped.
  assign capture   = sm_out_valid_i && ((state_q == SEND) || (state_q == WAIT))
                     && (rcvIdx_q < CW'(N));
  assign rcvIdx_d  = capture ? rcvIdx_q + CW'(1) : rcvIdx_q;
  assign idleCnt_d = idleCnt_q + TW'(1);

  // Host writes only land while idle so the buffer is stable during SEND.
  always_ff @(posedge clk_i) begin
    if (!rst_i && (state_q == IDLE) && wr_en_i) begin
      logitBuf[wr_addr_i] <= wr_data_i;
    end
  end

  // Result buffer fill; neither buffer is cleared by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && capture) begin
      resBuf[rcvIdx_q[AW-1:0]] <= sm_y_i;
    end
  end

  // Sequencer FSM. All outputs are registered and updated on the same edge
  // as the state, so they line up with the state they belong to.
  // sendIdx_q runs one ahead of the word on sm_x_o because sm_x_o is itself
  // a register loaded from the buffer on the preceding edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      sendIdx_q    <= '0;
      rcvIdx_q     <= '0;
      idleCnt_q    <= '0;
      clearCnt_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeoutErr_q <= 1'b0;
      smRst_q      <= 1'b0;
      smEnable_q   <= 1'b0;
      smInValid_q  <= 1'b0;
      smX_q        <= '0;
    end else begin
      done_q   <= 1'b0;
      rcvIdx_q <= rcvIdx_d;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q      <= CLEAR;
            busy_q       <= 1'b1;
            smRst_q      <= 1'b1;
            smEnable_q   <= 1'b1;
            timeoutErr_q <= 1'b0;
            sendIdx_q    <= '0;
            rcvIdx_q     <= '0;
            idleCnt_q    <= '0;
            clearCnt_q   <= 1'b0;
          end
        end
        CLEAR: begin
          if (!clearCnt_q) begin
            clearCnt_q <= 1'b1;
          end else begin
            state_q     <= SEND;
            smRst_q     <= 1'b0;
            smInValid_q <= 1'b1;
            smX_q       <= logitBuf[sendIdx_q[AW-1:0]];
            sendIdx_q   <= sendIdx_q + CW'(1);
          end
        end
        SEND: begin
          if (sendIdx_q == CW'(N)) begin
            state_q     <= WAIT;
            smInValid_q <= 1'b0;
            smX_q       <= '0;
          end else begin
            smX_q     <= logitBuf[sendIdx_q[AW-1:0]];
            sendIdx_q <= sendIdx_q + CW'(1);
          end
        end
        WAIT: begin
          // A capture on the timeout cycle takes priority and restarts the
          // idle count.
          if (rcvIdx_d == CW'(N)) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            idleCnt_q <= '0;
          end else if (capture) begin
            idleCnt_q <= '0;
          end else if (idleCnt_d == TW'(TIMEOUT)) begin
            idleCnt_q    <= idleCnt_d;
            timeoutErr_q <= 1'b1;
            state_q      <= DONE;
            done_q       <= 1'b1;
          end else begin
            idleCnt_q <= idleCnt_d;
          end
        end
        DONE: begin
          // Dropping the enable freezes the softmax unit until the next run.
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          smEnable_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SOFTMAX_SEQ_SUM_CHECK_EN
  localparam int ACCW = DW + AW;
  localparam logic [ACCW-1:0] SUM_REF = ACCW'(1) << OUT_BITS;

  logic [ACCW-1:0] acc_q;
  logic [ACCW-1:0] acc_d;
  logic [ACCW-1:0] accDiff;
  logic            sumErr_q;

  assign acc_d   = capture ? acc_q + ACCW'(sm_y_i) : acc_q;
  assign accDiff = (acc_d >= SUM_REF) ? acc_d - SUM_REF : SUM_REF - acc_d;

  // The sum is judged on the same edge that enters DONE after the Nth
  // capture, so acc_d already includes that last sample.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      sumErr_q <= 1'b0;
    end else if ((state_q == IDLE) && start_i) begin
      acc_q    <= '0;
      sumErr_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if ((state_q == WAIT) && (rcvIdx_d == CW'(N))) begin
        sumErr_q <= (accDiff > ACCW'(N));
      end
    end
  end

  assign sum_err_o = sumErr_q;
`else
  // The fractional width only feeds the sum check, so it has no effect here.
  assign sum_err_o = 1'b0 & OUT_BITS[0];
`endif

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign timeout_err_o = timeoutErr_q;
  assign sm_rst_o      = smRst_q;
  assign sm_enable_o   = smEnable_q;
  assign sm_in_valid_o = smInValid_q;
  assign sm_x_o        = smX_q;
  assign rd_data_o     = resBuf[rd_addr_i];

endmodule

// File: tb/tb_softmax_seq.sv
// Testbench for softmax_seq. The bench plays the host and stands in for the
// softmax unit. Logits it loads are the expected stream, and result words it
// drives into the sequencer are queued as the expected result buffer.
module tb_softmax_seq;

  localparam int N    = 32;
  localparam int DW   = 32;
  localparam int TO   = 16;
  localparam int OUTB = 8;
`ifdef SOFTMAX_SEQ_SUM_CHECK_EN
  localparam bit SUMCHK = 1'b1;
`else
  localparam bit SUMCHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wrEn = 1'b0;
  logic [4:0]    wrAddr = '0;
  logic [DW-1:0] wrData = '0;
  logic          start = 1'b0;
  logic          busy, done, timeoutErr, sumErr;
  logic [4:0]    rdAddr = '0;
  logic [DW-1:0] rdData;
  logic          smRst, smEnable, smInValid;
  logic [DW-1:0] smX;
  logic          smOutValid = 1'b0;
  logic [DW-1:0] smY = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [DW-1:0] pattern [N];
  logic [DW-1:0] expQ [$];
  logic [DW-1:0] obsX [$];
  int expSum;
  int startCyc, c0;
  int inCount, firstInCyc, lastInCyc;
  int rstCount, firstRstCyc;
  int doneCount, doneCyc;
  logic timeoutAtDone;

  softmax_seq #(.DW(DW), .N(N), .OUT_BITS(OUTB), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wrEn), .wr_addr_i(wrAddr),
    .wr_data_i(wrData), .start_i(start), .busy_o(busy), .done_o(done),
    .timeout_err_o(timeoutErr), .sum_err_o(sumErr), .rd_addr_i(rdAddr),
    .rd_data_o(rdData), .sm_rst_o(smRst), .sm_enable_o(smEnable),
    .sm_in_valid_o(smInValid), .sm_x_o(smX), .sm_out_valid_i(smOutValid),
    .sm_y_i(smY)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor sampling on the falling edge.
  always @(negedge clk) begin
    if (smInValid === 1'b1) begin
      if (inCount == 0) firstInCyc = cyc;
      lastInCyc = cyc;
      inCount++;
      obsX.push_back(smX);
    end
    if (smRst === 1'b1) begin
      if (rstCount == 0) firstRstCyc = cyc;
      rstCount++;
    end
    if (done === 1'b1) begin
      doneCount++;
      doneCyc = cyc;
      timeoutAtDone = timeoutErr;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clearMon();
    inCount = 0; rstCount = 0; doneCount = 0;
    firstInCyc = -1; lastInCyc = -1; firstRstCyc = -1; doneCyc = -1;
    obsX.delete(); expQ.delete(); expSum = 0;
  endtask

  task automatic loadPattern();
    for (int k = 0; k < N; k++) begin
      wrEn = 1'b1; wrAddr = 5'(k); wrData = pattern[k];
      @(posedge clk); #1;
    end
    wrEn = 1'b0;
  endtask

  task automatic pulseStart(input bit withWrite, input int addr, input logic [DW-1:0] data);
    start = 1'b1;
    if (withWrite) begin
      wrEn = 1'b1; wrAddr = 5'(addr); wrData = data; pattern[addr] = data;
    end
    startCyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; wrEn = 1'b0;
  endtask

  task automatic waitInputs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (inCount >= N) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic driveOutputs(input int n, input bit ramp, input logic [DW-1:0] v);
    c0 = cyc;
    for (int k = 0; k < n; k++) begin
      smOutValid = 1'b1;
      smY = ramp ? DW'(k) : v;
      if (k < N) begin expQ.push_back(smY); expSum += int'(smY); end
      @(posedge clk); #1;
    end
    smOutValid = 1'b0; smY = '0;
  endtask

  task automatic waitDone(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (doneCount > 0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  function automatic bit expSumErr(input int s);
    int d;
    d = (s > (1 << OUTB)) ? s - (1 << OUTB) : (1 << OUTB) - s;
    return SUMCHK && (d > N);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    checks++; if (timeoutErr !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout got=%b exp=0", timeoutErr); end
    checks++; if (sumErr !== 1'b0) begin failures++; $display("[TB] FAIL reset_sumerr got=%b exp=0", sumErr); end
    checks++; if (smRst !== 1'b0) begin failures++; $display("[TB] FAIL reset_smrst got=%b exp=0", smRst); end
    checks++; if (smEnable !== 1'b0) begin failures++; $display("[TB] FAIL reset_smen got=%b exp=0", smEnable); end
    checks++; if (smInValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_invalid got=%b exp=0", smInValid); end
    checks++; if (smX !== '0) begin failures++; $display("[TB] FAIL reset_smx got=%0h exp=0", smX); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_vector();
    bit ok;
    logic [DW-1:0] e;
    $display("[TB] zero vector run");
    for (int k = 0; k < N; k++) pattern[k] = '0;
    loadPattern();
    clearMon();
    pulseStart(1'b0, 0, '0);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL zero_busy got=%b exp=1", busy); end
    checks++; if (smEnable !== 1'b1) begin failures++; $display("[TB] FAIL zero_en_clear got=%b exp=1", smEnable); end
    waitInputs(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL zero_wait_inputs got=%0d exp=%0d", inCount, N); end
    driveOutputs(N, 1'b0, DW'(8));
    waitDone(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL zero_wait_done got=0 exp=1"); end
    checks++; if (firstRstCyc !== startCyc + 1) begin failures++; $display("[TB] FAIL zero_rst_first got=%0d exp=%0d", firstRstCyc, startCyc + 1); end
    checks++; if (rstCount !== 2) begin failures++; $display("[TB] FAIL zero_rst_count got=%0d exp=2", rstCount); end
    checks++; if (firstInCyc !== startCyc + 3) begin failures++; $display("[TB] FAIL zero_in_first got=%0d exp=%0d", firstInCyc, startCyc + 3); end
    checks++; if (lastInCyc !== startCyc + N + 2) begin failures++; $display("[TB] FAIL zero_in_last got=%0d exp=%0d", lastInCyc, startCyc + N + 2); end
    checks++; if (inCount !== N) begin failures++; $display("[TB] FAIL zero_in_count got=%0d exp=%0d", inCount, N); end
    checks++; if (doneCount !== 1) begin failures++; $display("[TB] FAIL zero_done_count got=%0d exp=1", doneCount); end
    checks++; if (doneCyc !== c0 + N) begin failures++; $display("[TB] FAIL zero_done_cyc got=%0d exp=%0d", doneCyc, c0 + N); end
    checks++; if (timeoutErr !== 1'b0) begin failures++; $display("[TB] FAIL zero_timeout got=%b exp=0", timeoutErr); end
    checks++; if (sumErr !== expSumErr(expSum)) begin failures++; $display("[TB] FAIL zero_sumerr got=%b exp=%b", sumErr, expSumErr(expSum)); end
    checks++; if (busy !== 1'b0 || smEnable !== 1'b0) begin failures++; $display("[TB] FAIL zero_idle got=%b%b exp=00", busy, smEnable); end
    for (int k = 0; k < N && k < obsX.size(); k++) begin
      checks++; if (obsX[k] !== pattern[k]) begin failures++; $display("[TB] FAIL zero_smx[%0d] got=%0h exp=%0h", k, obsX[k], pattern[k]); end
    end
    for (int k = 0; k < N; k++) begin
      rdAddr = 5'(k); #1;
      checks++;
      if (expQ.size() == 0) begin failures++; $display("[TB] FAIL zero_res[%0d] got=%0h exp=none", k, rdData); end
      else begin
        e = expQ.pop_front();
        if (rdData !== e) begin failures++; $display("[TB] FAIL zero_res[%0d] got=%0h exp=%0h", k, rdData, e); end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_extra_outputs();
    bit ok;
    logic [DW-1:0] e;
    $display("[TB] forty outputs with ramp values");
    for (int k = 0; k < N; k++) pattern[k] = DW'(k * 7 - 100);
    loadPattern();
    clearMon();
    pulseStart(1'b0, 0, '0);
    waitInputs(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL extra_wait_inputs got=%0d exp=%0d", inCount, N); end
    driveOutputs(N + 8, 1'b1, '0);
    waitDone(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL extra_wait_done got=0 exp=1"); end
    checks++; if (doneCount !== 1) begin failures++; $display("[TB] FAIL extra_done_count got=%0d exp=1", doneCount); end
    checks++; if (doneCyc !== c0 + N) begin failures++; $display("[TB] FAIL extra_done_cyc got=%0d exp=%0d", doneCyc, c0 + N); end
    checks++; if (sumErr !== expSumErr(expSum)) begin failures++; $display("[TB] FAIL extra_sumerr got=%b exp=%b", sumErr, expSumErr(expSum)); end
    checks++; if (obsX.size() !== N) begin failures++; $display("[TB] FAIL extra_x_count got=%0d exp=%0d", obsX.size(), N); end
    for (int k = 0; k < N && k < obsX.size(); k++) begin
      checks++; if (obsX[k] !== pattern[k]) begin failures++; $display("[TB] FAIL extra_smx[%0d] got=%0h exp=%0h", k, obsX[k], pattern[k]); end
    end
    for (int k = 0; k < N; k++) begin
      rdAddr = 5'(k); #1;
      checks++;
      if (expQ.size() == 0) begin failures++; $display("[TB] FAIL extra_res[%0d] got=%0h exp=none", k, rdData); end
      else begin
        e = expQ.pop_front();
        if (rdData !== e) begin failures++; $display("[TB] FAIL extra_res[%0d] got=%0h exp=%0h", k, rdData, e); end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    bit ok;
    $display("[TB] sink never answers");
    clearMon();
    pulseStart(1'b0, 0, '0);
    waitInputs(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL to_wait_inputs got=%0d exp=%0d", inCount, N); end
    waitDone(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL to_wait_done got=0 exp=1"); end
    checks++; if (doneCyc !== lastInCyc + 1 + TO) begin failures++; $display("[TB] FAIL to_done_cyc got=%0d exp=%0d", doneCyc, lastInCyc + 1 + TO); end
    checks++; if (timeoutAtDone !== 1'b1) begin failures++; $display("[TB] FAIL to_err_at_done got=%b exp=1", timeoutAtDone); end
    checks++; if (timeoutErr !== 1'b1) begin failures++; $display("[TB] FAIL to_err_sticky got=%b exp=1", timeoutErr); end
    checks++; if (sumErr !== 1'b0) begin failures++; $display("[TB] FAIL to_sumerr got=%b exp=0", sumErr); end
    checks++; if (doneCount !== 1) begin failures++; $display("[TB] FAIL to_done_count got=%0d exp=1", doneCount); end
    clearMon();
    pulseStart(1'b0, 0, '0);
    checks++; if (timeoutErr !== 1'b0) begin failures++; $display("[TB] FAIL to_cleared got=%b exp=0", timeoutErr); end
    waitInputs(ok);
    driveOutputs(N, 1'b0, DW'(8));
    waitDone(ok);
    checks++; if (!ok || doneCount !== 1) begin failures++; $display("[TB] FAIL to_rerun_done got=%0d exp=1", doneCount); end
    checks++; if (timeoutErr !== 1'b0) begin failures++; $display("[TB] FAIL to_rerun_err got=%b exp=0", timeoutErr); end
  endtask

  task automatic test_busy_ignore();
    bit ok;
    logic [DW-1:0] e;
    $display("[TB] start and write during SEND");
    for (int k = 0; k < N; k++) pattern[k] = DW'(32'h100 + k);
    pattern[5] = DW'(32'h11);
    loadPattern();
    clearMon();
    pulseStart(1'b0, 0, '0);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; wrEn = 1'b1; wrAddr = 5'd5; wrData = DW'(32'h7F);
    @(posedge clk); #1;
    start = 1'b0; wrEn = 1'b0;
    waitInputs(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL busy_wait_inputs got=%0d exp=%0d", inCount, N); end
    driveOutputs(N, 1'b0, DW'(8));
    waitDone(ok);
    repeat (40) @(posedge clk);
    #1;
    checks++; if (doneCount !== 1) begin failures++; $display("[TB] FAIL busy_done_count got=%0d exp=1", doneCount); end
    checks++; if (inCount !== N) begin failures++; $display("[TB] FAIL busy_in_count got=%0d exp=%0d", inCount, N); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL busy_idle got=%b exp=0", busy); end
    for (int k = 0; k < N && k < obsX.size(); k++) begin
      checks++; if (obsX[k] !== pattern[k]) begin failures++; $display("[TB] FAIL busy_smx[%0d] got=%0h exp=%0h", k, obsX[k], pattern[k]); end
    end
    for (int k = 0; k < N; k++) begin
      rdAddr = 5'(k); #1;
      checks++;
      if (expQ.size() == 0) begin failures++; $display("[TB] FAIL busy_res[%0d] got=%0h exp=none", k, rdData); end
      else begin
        e = expQ.pop_front();
        if (rdData !== e) begin failures++; $display("[TB] FAIL busy_res[%0d] got=%0h exp=%0h", k, rdData, e); end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun();
    bit ok;
    logic [DW-1:0] e;
    $display("[TB] reset in WAIT then clean run");
    clearMon();
    pulseStart(1'b0, 0, '0);
    waitInputs(ok);
    for (int k = 0; k < 5; k++) begin
      smOutValid = 1'b1; smY = DW'(99);
      @(posedge clk); #1;
    end
    smOutValid = 1'b0; smY = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (smEnable !== 1'b0) begin failures++; $display("[TB] FAIL mid_smen got=%b exp=0", smEnable); end
    checks++; if (smRst !== 1'b0) begin failures++; $display("[TB] FAIL mid_smrst got=%b exp=0", smRst); end
    @(posedge clk); #1;
    clearMon();
    pulseStart(1'b1, 3, DW'(32'h55));
    waitInputs(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL mid_wait_inputs got=%0d exp=%0d", inCount, N); end
    checks++; if (firstInCyc !== startCyc + 3) begin failures++; $display("[TB] FAIL mid_in_first got=%0d exp=%0d", firstInCyc, startCyc + 3); end
    checks++; if (rstCount !== 2) begin failures++; $display("[TB] FAIL mid_rst_count got=%0d exp=2", rstCount); end
    driveOutputs(N, 1'b0, DW'(10));
    waitDone(ok);
    checks++; if (!ok || doneCount !== 1) begin failures++; $display("[TB] FAIL mid_done got=%0d exp=1", doneCount); end
    checks++; if (timeoutErr !== 1'b0) begin failures++; $display("[TB] FAIL mid_timeout got=%b exp=0", timeoutErr); end
    checks++; if (sumErr !== expSumErr(expSum)) begin failures++; $display("[TB] FAIL mid_sumerr got=%b exp=%b", sumErr, expSumErr(expSum)); end
    for (int k = 0; k < N && k < obsX.size(); k++) begin
      checks++; if (obsX[k] !== pattern[k]) begin failures++; $display("[TB] FAIL mid_smx[%0d] got=%0h exp=%0h", k, obsX[k], pattern[k]); end
    end
    for (int k = 0; k < N; k++) begin
      rdAddr = 5'(k); #1;
      checks++;
      if (expQ.size() == 0) begin failures++; $display("[TB] FAIL mid_res[%0d] got=%0h exp=none", k, rdData); end
      else begin
        e = expQ.pop_front();
        if (rdData !== e) begin failures++; $display("[TB] FAIL mid_res[%0d] got=%0h exp=%0h", k, rdData, e); end
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    clearMon();
    test_reset();
    test_zero_vector();
    test_extra_outputs();
    test_timeout();
    test_busy_ignore();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/softmax_seq.md
# softmax_seq

Vector sequencer that drives the softmax streaming unit and collects its results. A host loads N logits into a local buffer, then pulses `start`. The block resets and enables the softmax unit, streams the logits one per cycle with `in_valid`, and captures the first N `out_valid` samples into a result buffer that the host can read. It sits between the host register/memory interface and the softmax datapath as the transmitter and receiver for that unit's stream.

## Interface
- `DW`, 32, logit and result word width
- `N`, 32, vector length; power of two, ≥2
- `OUT_BITS`, 8, fractional bits of softmax output; full-scale probability sum is 2^OUT_BITS
- `TIMEOUT`, 1024, maximum idle cycles in WAIT before abort
- One clock; reset is synchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `wr_en`  in  1  host write strobe to logit buffer
- `wr_addr`  in  $clog2(N)  logit buffer index
- `wr_data`  in  DW  signed logit
- `start`  in  1  begin one vector run
- `busy`  out  1  high from start acceptance until DONE exits
- `done`  out  1  one-cycle pulse at end of run, whether normal or aborted
- `timeout_err`  out  1  sticky; last run aborted in WAIT
- `sum_err`  out  1  sticky; result sum out of range (see Configuration)
- `rd_addr`  in  $clog2(N)  result buffer index
- `rd_data`  out  DW  result word; combinational read
- `sm_rst`  out  1  reset to softmax unit
- `sm_enable`  out  1  enable to softmax unit
- `sm_in_valid`  out  1  logit valid to softmax unit
- `sm_x`  out  DW  logit to softmax unit
- `sm_out_valid`  in  1  result valid from softmax unit
- `sm_y`  in  DW  result from softmax unit

## Operation
- States: IDLE, CLEAR, SEND, WAIT, DONE.
- IDLE:
  - `wr_en` writes `buf[wr_addr] <= wr_data`.
  - `start` moves to CLEAR, clears `timeout_err` and `sum_err`, and zeroes the counters.
- CLEAR:
  - 2 cycles with `sm_rst=1` and `sm_enable=1`. The softmax unit only honours reset while enabled.
  - Then moves to SEND.
- SEND:
  - N cycles with `sm_in_valid=1` and `sm_x=buf[send_idx]`.
  - `send_idx` runs 0..N-1. Moves to WAIT after index N-1.
- WAIT:
  - Each cycle with `sm_out_valid=1` writes `res[rcv_idx] <= sm_y` and increments `rcv_idx`.
  - Reaching `rcv_idx==N` moves to DONE.
  - `idle_cnt` resets on each capture and increments otherwise. `idle_cnt==TIMEOUT` sets `timeout_err` and moves to DONE.
- Captures are also taken in SEND if `sm_out_valid` rises early. Captures are never taken after N samples. Extra `sm_out_valid` cycles are ignored.
- DONE: one cycle, `done=1`, then IDLE.
- `sm_enable` is 1 in CLEAR, SEND, WAIT and DONE, and 0 in IDLE. This freezes the softmax unit between runs.
- `busy` is 1 in every state except IDLE.
- `start` while `busy` is ignored. `wr_en` while `busy` is ignored, so the buffer is stable during SEND.
- `rd_data = res[rd_addr]` at any time. Reads during a run may return partial results.

## Timing
- Reset values:
  - `busy=0`, `done=0`, `timeout_err=0`, `sum_err=0`
  - `sm_rst=0`, `sm_enable=0`, `sm_in_valid=0`, `sm_x=0`
  - state IDLE; all counters 0
- Buffers are not cleared by reset.
- `start` sampled high at cycle t:
  - `sm_rst=1` at t+1 and t+2
  - first `sm_in_valid` at t+3
  - last `sm_in_valid` at t+N+2
- `done` pulses the cycle after the Nth capture.
- Write and start in the same IDLE cycle: the write lands, and SEND reads the new value.
- `rst` mid-run returns the block to IDLE within one cycle with `sm_enable=0`. The softmax unit is left un-reset until the next CLEAR.
- Capture and timeout in the same cycle: the capture wins and `idle_cnt` resets.
- Counters use `$clog2(N)+1` bits so that N is representable. `idle_cnt` uses `$clog2(TIMEOUT)+1` bits.

## Configuration
- Macro: `SOFTMAX_SEQ_SUM_CHECK_EN`.
- Defined:
  - Each capture adds `sm_y` into `acc`, which is `DW+$clog2(N)` bits unsigned and zeroed at `start`.
  - On entry to DONE after N captures, `sum_err` is set if `|acc - 2^OUT_BITS| > N`.
- Undefined: no accumulator; `sum_err` is tied to 0.

## Test plan
- Load all logits 0 (N=32), start:
  - `sm_in_valid` high for exactly 32 cycles beginning at t+3
  - softmax outputs captured; all 32 `res` equal (8 each for OUT_BITS=8)
  - `done` pulses once, `timeout_err=0`
- Stub sink asserts `sm_out_valid` 40 cycles with `sm_y=k`:
  - `res[k]=k` for k=0..31
  - samples 32..39 ignored
  - `rcv_idx` stops at 32
- Stub sink never asserts `sm_out_valid`, `TIMEOUT=16`:
  - `timeout_err=1` and `done` pulse at 16 cycles into WAIT
  - next `start` clears `timeout_err`
- `start` pulsed during SEND, and `wr_en` to addr 5 with 0x7F during SEND:
  - second start ignored
  - `buf[5]` unchanged; one `done` only
- `rst` asserted in WAIT:
  - next cycle: `busy=0`, `sm_enable=0`
  - a following start runs a clean full vector
- `SOFTMAX_SEQ_SUM_CHECK_EN` defined, stub returns 32×8: `sum_err=0`. Stub returns 32×10: `sum_err=1`. Macro undefined: `sum_err=0` in both cases.
